// File: rtl/round_robin_arbiter2.sv
// ---------------------------------------------------------------------------
// round_robin_arbiter2
//   Registered N-way round-robin arbiter. Every rising edge it samples the
//   request vector and issues a one-hot grant to one requester. The requester
//   granted most recently drops to lowest priority for the next decision, so
//   every active requester is eventually served.
//
// Parameters
//   N      number of requesters (N >= 2)
//
// Ports
//   clk    in   1   system clock, rising-edge active
//   rst_n  in   1   asynchronous reset, active low
//   req    in   N   level request vector, bit i = requester i wants access
//   grant  out  N   registered one-hot grant, all zero when nothing granted
// ---------------------------------------------------------------------------
module round_robin_arbiter2 #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [N-1:0]     grant_q;
    logic [N-1:0]     grant_d;

    logic [N-1:0]     maskedReq;
    logic [PTR_W-1:0] winIdx;
    logic             winValid;

    // Masked-priority search. Requests strictly above the last-granted index
    // are considered first; if none of those are active the search wraps and
    // takes the lowest active request overall. This gives the (ptr+1) mod N
    // starting point for any N without special-casing the wrap.
    always_comb begin
        maskedReq = '0;
        winIdx    = '0;
        winValid  = 1'b0;

        for (int i = 0; i < N; i++) begin
            if (PTR_W'(i) > ptr_q) begin
                maskedReq[i] = req[i];
            end
        end

        // Scan downward so the lowest set bit is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (maskedReq[i]) begin
                winIdx   = PTR_W'(i);
                winValid = 1'b1;
            end
        end

        if (!winValid) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req[i]) begin
                    winIdx   = PTR_W'(i);
                    winValid = 1'b1;
                end
            end
        end
    end

    // Next-state: a winner gets a one-hot grant and becomes the new pointer;
    // with no requests the grant clears and the pointer keeps its history.
    always_comb begin
        grant_d = '0;
        ptr_d   = ptr_q;
        if (winValid) begin
            grant_d[winIdx] = 1'b1;
            ptr_d           = winIdx;
        end
    end

    // State registers. Reset parks the pointer on the last requester so that
    // requester 0 is first in line once reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
            ptr_q   <= PTR_LAST;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter2.sv
module tb_round_robin_arbiter2;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [1:0] grant;
    logic [2:0] req3;
    logic [2:0] grant3;

    int errorCount;
    int checkCount;

    // Default two-requester arbiter, the main device under test.
    round_robin_arbiter2 #(.N(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant)
    );

    // Three-requester instance to exercise the pointer wrap for a non-power-of-two N.
    round_robin_arbiter2 #(.N(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req3),
        .grant (grant3)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one observed value against the hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [2:0] observed, input logic [2:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Drives both request vectors, then advances to just after the next rising edge.
    task automatic applyStimulus(input logic [1:0] newReq, input logic [2:0] newReq3);
        req  = newReq;
        req3 = newReq3;
        @(posedge clk);
        #1;
    endtask

    // Checks both grants together.
    task automatic checkBoth(input string tag, input logic [1:0] exp2, input logic [2:0] exp3);
        checkOutput({tag, "_n2"}, {1'b0, grant}, {1'b0, exp2});
        checkOutput({tag, "_n3"}, grant3, exp3);
    endtask

    // Directed sequence with hand-computed expected grants.
    initial begin
        errorCount = 0;
        checkCount = 0;
        rst_n = 1'b0;
        req   = 2'b00;
        req3  = 3'b000;

        // Reset is asynchronous: grant must be zero before any clock edge.
        #1;
        checkBoth("reset_no_clock", 2'b00, 3'b000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 3'b000);
            checkBoth("reset_held", 2'b00, 3'b000);
        end

        // Release reset with no requests.
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, 3'b000);
            checkBoth("idle", 2'b00, 3'b000);
        end

        // Lone requester 0 is granted every cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, 3'b000);
            checkOutput("lone_req0", {1'b0, grant}, 3'b001);
        end

        // Lone requester 1.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b10, 3'b000);
            checkOutput("lone_req1", {1'b0, grant}, 3'b010);
        end

        // Both request after last grant went to 1: alternate starting with 0.
        applyStimulus(2'b11, 3'b000);
        checkOutput("contend_1", {1'b0, grant}, 3'b001);
        applyStimulus(2'b11, 3'b000);
        checkOutput("contend_2", {1'b0, grant}, 3'b010);
        applyStimulus(2'b11, 3'b000);
        checkOutput("contend_3", {1'b0, grant}, 3'b001);

        // Reset mid-arbitration, between edges: grant clears at once.
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async", {1'b0, grant}, 3'b000);
        applyStimulus(2'b11, 3'b000);
        checkOutput("midreset_held", {1'b0, grant}, 3'b000);

        // After release priority restarts at requester 0.
        rst_n = 1'b1;
        applyStimulus(2'b11, 3'b000);
        checkOutput("post_reset_1", {1'b0, grant}, 3'b001);
        applyStimulus(2'b11, 3'b000);
        checkOutput("post_reset_2", {1'b0, grant}, 3'b010);

        // Dropping all requests removes the grant on the next edge.
        applyStimulus(2'b00, 3'b000);
        checkBoth("drop_req", 2'b00, 3'b000);

        // N=3: full contention rotates 0,1,2 and wraps back to 0.
        applyStimulus(2'b00, 3'b111);
        checkOutput("n3_all_1", grant3, 3'b001);
        applyStimulus(2'b00, 3'b111);
        checkOutput("n3_all_2", grant3, 3'b010);
        applyStimulus(2'b00, 3'b111);
        checkOutput("n3_all_3", grant3, 3'b100);
        applyStimulus(2'b00, 3'b111);
        checkOutput("n3_all_wrap", grant3, 3'b001);

        // N=3: requesters 0 and 2 with pointer at 0 skip idle requester 1.
        applyStimulus(2'b00, 3'b101);
        checkOutput("n3_skip_1", grant3, 3'b100);
        applyStimulus(2'b00, 3'b101);
        checkOutput("n3_skip_2", grant3, 3'b001);
        applyStimulus(2'b00, 3'b101);
        checkOutput("n3_skip_3", grant3, 3'b100);

        // N=3: lone middle requester, then 1 and 2 contending from pointer 1.
        applyStimulus(2'b00, 3'b010);
        checkOutput("n3_lone1", grant3, 3'b010);
        applyStimulus(2'b00, 3'b110);
        checkOutput("n3_pair_1", grant3, 3'b100);
        applyStimulus(2'b00, 3'b110);
        checkOutput("n3_pair_2", grant3, 3'b010);
        applyStimulus(2'b00, 3'b110);
        checkOutput("n3_pair_3", grant3, 3'b100);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
